// File: rtl/parking_lot_controller.sv
// Occupancy manager and entry-gate sequencer for the parking lot.
// It keeps a saturating car count and runs the entry barrier
// through three states: IDLE, OPEN and CLOSE.
module parking_lot_controller #(
  parameter int unsigned CAPACITY     = 15,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned GATE_TIMEOUT = 50,
  parameter int unsigned TMR_W        = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_enter,
  input  logic             car_exit,
  input  logic             entry_req,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             lot_full,
  output logic             lot_empty,
  output logic             entry_denied,
  output logic             count_error
);

  localparam logic [CNT_W-1:0] CAP_VAL  = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } gate_state_t;

  gate_state_t      state;
  logic [TMR_W-1:0] timer;

  // Flags are decoded straight from the occupancy register.
  assign lot_full  = (occupancy == CAP_VAL);
  assign lot_empty = (occupancy == '0);

  // Saturating occupancy counter; a simultaneous enter and exit cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy   <= '0;
      count_error <= 1'b0;
    end else begin
      count_error <= 1'b0;
      unique case ({car_enter, car_exit})
        2'b10: begin
          if (occupancy < CAP_VAL) occupancy <= occupancy + CNT_W'(1);
          else                     count_error <= 1'b1;
        end
        2'b01: begin
          if (occupancy != '0) occupancy <= occupancy - CNT_W'(1);
          else                 count_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Entry barrier sequencer: grant when there is space, close on a car or on timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      gate_open    <= 1'b0;
      entry_denied <= 1'b0;
    end else begin
      entry_denied <= 1'b0;
      unique case (state)
        IDLE: begin
          if (entry_req) begin
            if (!lot_full) begin
              state     <= OPEN;
              timer     <= TMR_LOAD;
              gate_open <= 1'b1;
            end else begin
              entry_denied <= 1'b1;
            end
          end
        end
        OPEN: begin
          if (car_enter || (timer == '0)) begin
            state     <= CLOSE;
            gate_open <= 1'b0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        CLOSE: begin
          state     <= IDLE;
          gate_open <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          gate_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_lot_controller.sv
// Scoreboard bench for parking_lot_controller (CAPACITY=3, GATE_TIMEOUT=4).
// The driver queues the expected post-edge outputs for each cycle.
// A monitor pops one entry after every rising edge and compares it.
module tb_parking_lot_controller;

  localparam int unsigned CAP   = 3;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [CNT_W-1:0] occ;
    logic             gate;
    logic             denied;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             car_enter = 1'b0;
  logic             car_exit = 1'b0;
  logic             entry_req = 1'b0;
  logic             gate_open;
  logic [CNT_W-1:0] occupancy;
  logic             lot_full;
  logic             lot_empty;
  logic             entry_denied;
  logic             count_error;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  parking_lot_controller #(
    .CAPACITY    (CAP),
    .CNT_W       (CNT_W),
    .GATE_TIMEOUT(4),
    .TMR_W       (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .car_enter   (car_enter),
    .car_exit    (car_exit),
    .entry_req   (entry_req),
    .gate_open   (gate_open),
    .occupancy   (occupancy),
    .lot_full    (lot_full),
    .lot_empty   (lot_empty),
    .entry_denied(entry_denied),
    .count_error (count_error)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, vec_no, act, req);
    end
  endtask

  // Monitor: compares the outputs registered at each edge against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vec_no++;
      cmp("occupancy",    int'(occupancy),    int'(e.occ));
      cmp("gate_open",    int'(gate_open),    int'(e.gate));
      cmp("entry_denied", int'(entry_denied), int'(e.denied));
      cmp("count_error",  int'(count_error),  int'(e.err));
      cmp("lot_full",     int'(lot_full),     (int'(e.occ) == CAP) ? 1 : 0);
      cmp("lot_empty",    int'(lot_empty),    (int'(e.occ) == 0) ? 1 : 0);
    end
  end

  // One cycle of stimulus plus the outputs required after the next rising edge.
  task automatic v(input logic rst, input logic en, input logic ex, input logic req,
                   input int occ, input logic gate, input logic den, input logic err);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    car_enter = en;
    car_exit  = ex;
    entry_req = req;
    e.occ    = CNT_W'(occ);
    e.gate   = gate;
    e.denied = den;
    e.err    = err;
    exp_q.push_back(e);
  endtask

  initial begin
    //     rst en ex req  occ gate den err
    v(1'b1, 0, 0, 0,   0, 0, 0, 0);   // reset
    // Counting up, one change per pulse
    v(1'b0, 1, 0, 0,   1, 0, 0, 0);
    v(1'b0, 0, 0, 0,   1, 0, 0, 0);
    v(1'b0, 1, 0, 0,   2, 0, 0, 0);
    v(1'b0, 0, 0, 0,   2, 0, 0, 0);
    v(1'b0, 1, 0, 0,   3, 0, 0, 0);
    v(1'b0, 0, 0, 0,   3, 0, 0, 0);
    // Full lot: every held request is refused, gate stays shut
    v(1'b0, 0, 0, 1,   3, 0, 1, 0);
    v(1'b0, 0, 0, 1,   3, 0, 1, 0);
    v(1'b0, 0, 0, 1,   3, 0, 1, 0);
    v(1'b0, 0, 0, 0,   3, 0, 0, 0);
    // Enter while full saturates and flags an error
    v(1'b0, 1, 0, 0,   3, 0, 0, 1);
    v(1'b0, 0, 0, 0,   3, 0, 0, 0);
    // Enter and exit together at full: no change, no error
    v(1'b0, 1, 1, 0,   3, 0, 0, 0);
    v(1'b0, 0, 1, 0,   2, 0, 0, 0);
    // Grant, then a car closes the gate before the timeout
    v(1'b0, 0, 0, 1,   2, 1, 0, 0);
    v(1'b0, 0, 0, 0,   2, 1, 0, 0);
    v(1'b0, 0, 0, 0,   2, 1, 0, 0);
    v(1'b0, 1, 0, 0,   3, 0, 0, 0);   // CLOSE
    v(1'b0, 0, 0, 0,   3, 0, 0, 0);   // back to IDLE
    v(1'b0, 0, 0, 1,   3, 0, 1, 0);   // IDLE again: full, so denied
    v(1'b0, 0, 1, 0,   2, 0, 0, 0);
    v(1'b0, 0, 1, 0,   1, 0, 0, 0);
    // Enter and exit together at 1: no change
    v(1'b0, 1, 1, 0,   1, 0, 0, 0);
    // Held request, no car: 4 open cycles, CLOSE, IDLE, then a re-grant
    v(1'b0, 0, 0, 1,   1, 1, 0, 0);
    v(1'b0, 0, 0, 1,   1, 1, 0, 0);
    v(1'b0, 0, 0, 1,   1, 1, 0, 0);
    v(1'b0, 0, 0, 1,   1, 1, 0, 0);
    v(1'b0, 0, 0, 1,   1, 0, 0, 0);
    v(1'b0, 0, 0, 1,   1, 0, 0, 0);
    v(1'b0, 0, 0, 1,   1, 1, 0, 0);
    v(1'b0, 0, 0, 0,   1, 1, 0, 0);
    // Reset while the gate is open
    v(1'b1, 0, 0, 0,   0, 0, 0, 0);
    v(1'b0, 0, 0, 1,   0, 1, 0, 0);
    v(1'b0, 0, 0, 0,   0, 1, 0, 0);
    v(1'b0, 0, 0, 0,   0, 1, 0, 0);
    v(1'b0, 0, 0, 0,   0, 1, 0, 0);
    v(1'b0, 0, 0, 0,   0, 0, 0, 0);   // timed out
    v(1'b0, 0, 0, 0,   0, 0, 0, 0);
    // Exit while empty saturates and flags an error
    v(1'b0, 0, 1, 0,   0, 0, 0, 1);
    v(1'b0, 0, 0, 0,   0, 0, 0, 0);

    @(negedge clk);
    car_enter = 1'b0;
    car_exit  = 1'b0;
    entry_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
